instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/next_pc_calc.sv | 36 +++
 rtl/instr_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Contents: opcode constants (instr[6:0]), the NOP encoding loaded into the
// instruction register at reset, the fetch FSM state enum and the default
// reset PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds the TRAP state.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013; // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    ST_ISSUE = 2'd2,
    ST_TRAP  = 2'd3
`else
    ST_ISSUE = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection (purely combinational).
// Ports:
//   pc, imm, rs1_data : current PC, sign-extended immediate, rs1 value
//   branch, jal, jalr, zero : decoder selects and ALU zero flag
//   next_pc           : address of the next fetch
// Priority: JALR, then JAL / taken branch, then sequential pc+4.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is undefined the
// two low address bits are cleared here; when defined they are passed
// through so the fetch FSM can detect a misaligned target.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] target;

  always_comb begin
    target = pc + 32'd4;
    if (jalr) begin
      target = (rs1_data + imm) & ~32'h1;
    end else if (jal || (branch && zero)) begin
      target = pc + imm;
    end
    next_pc = target;
`ifndef FETCH_MISALIGN_TRAP_EN
    next_pc[1:0] = 2'b00;
`endif
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one instruction at a time from
// instruction memory, holds it for the core, and advances the PC when the
// core accepts it.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   imem_req_o/addr_o   : memory request and address (the PC)
//   imem_ack_i/rdata_i  : memory reply strobe and data
//   instr_o/valid_o     : latched instruction and its valid flag
//   core_ready_i        : core accepts instr_o (issue handshake)
//   pc_o, pc_plus4_o    : PC of instr_o and PC+4
//   Branch_i, Jal_i, Jalr_i, Zero_i, imm_i, rs1_data_i : next-PC controls
//   retired_o           : count of completed issue handshakes (wraps)
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a handshake whose
// next PC has bit 1 set parks the unit in TRAP until reset.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        core_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        Branch_i,
  input  logic        Jal_i,
  input  logic        Jalr_i,
  input  logic        Zero_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] retired_o
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic [31:0]  retired;
  logic [31:0]  next_pc;
  logic         handshake;

  next_pc_calc u_next_pc (
    .pc       (pc),
    .imm      (imm_i),
    .rs1_data (rs1_data_i),
    .branch   (Branch_i),
    .jal      (Jal_i),
    .jalr     (Jalr_i),
    .zero     (Zero_i),
    .next_pc  (next_pc)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; controls matter only on the handshake cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (imem_ack_i) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (core_ready_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_next = next_pc[1] ? ST_TRAP : ST_FETCH;
`else
          state_next = ST_FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_TRAP:  state_next = ST_TRAP;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode; TRAP and IDLE drive neither request nor valid
  always_comb begin
    imem_req_o    = (state == ST_FETCH);
    instr_valid_o = (state == ST_ISSUE);
  end

  assign handshake = instr_valid_o && core_ready_i;

  // PC, instruction register and retire counter. An ack seen outside FETCH
  // (including the first cycle after reset, which is IDLE) is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      retired <= 32'd0;
    end else begin
      if ((state == ST_FETCH) && imem_ack_i) begin
        instr <= imem_rdata_i;
      end
      if (handshake) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + 32'd4;
  assign instr_o     = instr;
  assign retired_o   = retired;

endmodule
